// File: rtl/gpio_ctrl_if.sv
// Peripheral bus bundle for gpio_ctrl: single-cycle request, registered ack/read data.
interface gpio_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (output req_i, we_i, addr_i, data_i, input data_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: NUM_PINS bidirectional GPIO with per-pin direction, synchronised
// inputs, edge-detect pending flags and a combined level IRQ.
// Optional macro GPIO_DEBOUNCE_EN adds a per-pin stability counter after the
// synchroniser (DEBOUNCE_CYCLES stable cycles before a new level is accepted).

// Per-pin input path: synchroniser, optional debounce, edge detect, pending flag.
module gpio_pin #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic rise,   // 1 = rising edge event, 0 = falling
  input  logic clr,    // W1C strobe for the pending flag
  output logic lvl,    // accepted (synchronised) level
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   evt;

  // Synchroniser chain; the pad is asynchronous.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};

`ifdef GPIO_DEBOUNCE_EN
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt;

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; a bounce back restarts the count.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == lvl) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      lvl <= sync_q[SYNC_STAGES-1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
`else
  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYCLES;
  assign lvl       = sync_q[SYNC_STAGES-1];
`endif

  // Event uses the delayed level only, so flipping 'rise' never fires by itself.
  assign evt = rise ? (lvl & ~prev) : (~lvl & prev);

  // Edge history and pending flag; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= lvl;
      if (evt)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
endmodule

module gpio_ctrl #(
  parameter int NUM_PINS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  gpio_ctrl_if.slave          bus,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq_o
);
  localparam logic [4:0] A_DIR  = 5'h00;
  localparam logic [4:0] A_DATA = 5'h04;
  localparam logic [4:0] A_IN   = 5'h08;
  localparam logic [4:0] A_IE   = 5'h0C;
  localparam logic [4:0] A_EDGE = 5'h10;
  localparam logic [4:0] A_PEND = 5'h14;

  logic [NUM_PINS-1:0] dir_q, data_q, ie_q, edge_q;
  logic [NUM_PINS-1:0] in_w, pend_w, pend_clr;
  logic [NUM_PINS-1:0] wd;
  logic [4:0]          a;
  logic                wr;
  logic [31:0]         rdata;

  logic unused_bus;
  assign unused_bus = ^{bus.addr_i[31:5], bus.data_i};

  assign a        = bus.addr_i[4:0];
  assign wd       = bus.data_i[NUM_PINS-1:0];
  assign wr       = bus.req_i & bus.we_i;
  assign pend_clr = (wr && a == A_PEND) ? wd : '0;

  gpio_pin #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pin [NUM_PINS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .pad  (gpio_i),
    .rise (edge_q),
    .clr  (pend_clr),
    .lvl  (in_w),
    .pend (pend_w)
  );

  // Control register writes; IN and PEND are handled elsewhere.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dir_q  <= '0;
      data_q <= '0;
      ie_q   <= '0;
      edge_q <= '0;
    end else if (wr) begin
      case (a)
        A_DIR:   dir_q  <= wd;
        A_DATA:  data_q <= wd;
        A_IE:    ie_q   <= wd;
        A_EDGE:  edge_q <= wd;
        default: ;
      endcase
    end

  // Read mux; unused bits and unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    case (a)
      A_DIR:   rdata[NUM_PINS-1:0] = dir_q;
      A_DATA:  rdata[NUM_PINS-1:0] = data_q;
      A_IN:    rdata[NUM_PINS-1:0] = in_w;
      A_IE:    rdata[NUM_PINS-1:0] = ie_q;
      A_EDGE:  rdata[NUM_PINS-1:0] = edge_q;
      A_PEND:  rdata[NUM_PINS-1:0] = pend_w;
      default: rdata = '0;
    endcase
  end

  // Registered ack/data: pre-write values are returned for the request edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.ack_o  <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.ack_o  <= bus.req_i;
      bus.data_o <= bus.req_i ? rdata : '0;
    end

  // Level interrupt from enabled pending flags.
  always_ff @(posedge clk or negedge rst)
    if (!rst) irq_o <= 1'b0;
    else      irq_o <= |(pend_w & ie_q);

  assign gpio_o  = data_q;
  assign gpio_oe = dir_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: every bus request queues its expected read
// data; a negedge monitor pops and compares when ack_o is seen.
module tb_gpio_ctrl;
  localparam int NP = 8;
  localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int DLY = SS + DB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] gpio_i = '0;
  logic [NP-1:0] gpio_o, gpio_oe;
  logic          irq_o;

  gpio_ctrl_if bif ();

  gpio_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif.slave),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus request; exp is the read data owed for it (old value on writes).
  task automatic bus_req(logic we, logic [31:0] a, logic [31:0] d, logic [31:0] exp, string tag);
    bif.req_i  = 1'b1;
    bif.we_i   = we;
    bif.addr_i = a;
    bif.data_i = d;
    @(posedge clk);
    sbq.push_back(sb_t'{tag, exp});
    #1;
    bif.req_i = 1'b0;
    bif.we_i  = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".ack"}, 32'(bif.ack_o), 32'd1);
        chk(e.tag, bif.data_o, e.exp);
      end else if (bif.ack_o) begin
        chk("spurious_ack", 32'(bif.ack_o), 32'd0);
      end
    end
  end

  initial begin
    bif.req_i  = 1'b0;
    bif.we_i   = 1'b0;
    bif.addr_i = '0;
    bif.data_i = '0;
    tick(3);
    rst = 1'b1;
    tick(2);

    // 1: reset in the middle of operation
    bus_req(1'b1, 32'h00, 32'hFF, 32'h0, "w_dir0");
    bus_req(1'b1, 32'h04, 32'hA5, 32'h0, "w_data0");
    chk("oe_pre", 32'(gpio_oe), 32'hFF);
    chk("o_pre", 32'(gpio_o), 32'hA5);
    tick(1);
    #2 rst = 1'b0;
    #1;
    chk("oe_in_rst", 32'(gpio_oe), 32'h0);
    chk("o_in_rst", 32'(gpio_o), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("irq_rst", 32'(irq_o), 32'h0);
    chk("ack_rst", 32'(bif.ack_o), 32'h0);
    chk("dout_rst", bif.data_o, 32'h0);
    for (int a = 0; a <= 20; a += 4)
      bus_req(1'b0, 32'(a), 32'h0, 32'h0, $sformatf("rst_rd%0h", a));

    // 2: direction / data outputs, back-to-back reads, read-during-write
    bus_req(1'b1, 32'h00, 32'hFF, 32'h0, "w_dir");
    chk("oe_ff", 32'(gpio_oe), 32'hFF);
    bus_req(1'b1, 32'h04, 32'h3C, 32'h0, "w_data");
    chk("o_3c", 32'(gpio_o), 32'h3C);
    bus_req(1'b0, 32'h04, 32'h0, 32'h3C, "r_data");
    bus_req(1'b0, 32'h00, 32'h0, 32'hFF, "r_dir");
    bus_req(1'b1, 32'h00, 32'hFFFF_FFFF, 32'hFF, "w_dir_wide");
    bus_req(1'b0, 32'h00, 32'h0, 32'hFF, "r_dir_wide");
    bus_req(1'b1, 32'h04, 32'h55, 32'h3C, "w_data_old");
    bus_req(1'b0, 32'h04, 32'h0, 32'h55, "r_data55");
    chk("o_55", 32'(gpio_o), 32'h55);

    // 3: input latency, IN read-only, unmapped offsets
    gpio_i = 8'h81;
    tick(DLY - 1);
    bus_req(1'b0, 32'h08, 32'h0, 32'h00, "r_in_early");
    bus_req(1'b0, 32'h08, 32'h0, 32'h81, "r_in_81");
    bus_req(1'b1, 32'h08, 32'h00, 32'h81, "w_in");
    bus_req(1'b0, 32'h08, 32'h0, 32'h81, "r_in_keep");
    bus_req(1'b1, 32'h1C, 32'hFFFF, 32'h0, "w_1c");
    bus_req(1'b0, 32'h1C, 32'h0, 32'h0, "r_1c");
    bus_req(1'b0, 32'h18, 32'h0, 32'h0, "r_18");
    // default EDGE=0: returning low is a falling event on pins 0 and 7
    gpio_i = 8'h00;
    tick(DLY + 3);
    bus_req(1'b0, 32'h14, 32'h0, 32'h81, "r_pend_fall");
    chk("irq_masked", 32'(irq_o), 32'h0);
    bus_req(1'b1, 32'h14, 32'hFF, 32'h81, "w_pend_all");
    bus_req(1'b0, 32'h14, 32'h0, 32'h00, "r_pend_clr");

    // 4: rising IRQ on pin 0, falling pending on pin 1 without IRQ
    bus_req(1'b1, 32'h10, 32'h01, 32'h0, "w_edge");
    bus_req(1'b1, 32'h0C, 32'h01, 32'h0, "w_ie");
    gpio_i = 8'h01;
    tick(DLY + 3);
    chk("irq_p0", 32'(irq_o), 32'h1);
    bus_req(1'b0, 32'h14, 32'h0, 32'h01, "r_pend01");
    gpio_i = 8'h03;
    tick(DLY + 3);
    bus_req(1'b0, 32'h14, 32'h0, 32'h01, "r_pend_p1rise");
    gpio_i = 8'h01;
    tick(DLY + 3);
    bus_req(1'b0, 32'h14, 32'h0, 32'h03, "r_pend03");
    chk("irq_p0p1", 32'(irq_o), 32'h1);
    bus_req(1'b0, 32'h08, 32'h0, 32'h01, "r_in01");

    // 5: W1C, IRQ only from pin 0, set-beats-clear, write-0 no-op, IE mask
    bus_req(1'b1, 32'h14, 32'h01, 32'h03, "w_pend_c0");
    tick(1);
    chk("irq_p1_only", 32'(irq_o), 32'h0);
    bus_req(1'b0, 32'h14, 32'h0, 32'h02, "r_pend02");
    gpio_i = 8'h00;
    tick(DLY + 3);
    gpio_i = 8'h01;
    tick(DLY);
    bus_req(1'b1, 32'h14, 32'h01, 32'h02, "w_pend_race");
    tick(1);
    bus_req(1'b0, 32'h14, 32'h0, 32'h03, "r_pend_race");
    chk("irq_race", 32'(irq_o), 32'h1);
    bus_req(1'b1, 32'h14, 32'h00, 32'h03, "w_pend_zero");
    bus_req(1'b0, 32'h14, 32'h0, 32'h03, "r_pend_zero");
    bus_req(1'b1, 32'h0C, 32'h00, 32'h01, "w_ie_off");
    tick(1);
    chk("irq_ie_off", 32'(irq_o), 32'h0);
    bus_req(1'b0, 32'h14, 32'h0, 32'h03, "r_pend_kept");
    bus_req(1'b1, 32'h14, 32'hFF, 32'h03, "w_pend_ff");
    bus_req(1'b0, 32'h14, 32'h0, 32'h00, "r_pend_empty");

`ifdef GPIO_DEBOUNCE_EN
    // 6: glitch rejected, stable level accepted at exactly SS+16
    gpio_i = 8'h05;
    tick(5);
    gpio_i = 8'h01;
    tick(30);
    bus_req(1'b0, 32'h08, 32'h0, 32'h01, "r_in_glitch");
    bus_req(1'b0, 32'h14, 32'h0, 32'h00, "r_pend_glitch");
    gpio_i = 8'h05;
    tick(DLY - 1);
    bus_req(1'b0, 32'h08, 32'h0, 32'h01, "r_in_db_early");
    bus_req(1'b0, 32'h08, 32'h0, 32'h05, "r_in_db");
    tick(20);
`endif

    tick(2);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised GPIO controller; successor to the single-pin output-only GPIO peripheral.
- Provides NUM_PINS bidirectional pins with per-pin direction, synchronised input sampling, per-pin edge-detect interrupts and a combined IRQ line.
- Sits on the peripheral bus alongside the timer and UART, keeps the legacy data register at offset 0x4, and drives the top-level pads and the interrupt controller.

Parameters:
- NUM_PINS, 8, number of GPIO pins (1..32); register bits at and above NUM_PINS read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..3).
- DEBOUNCE_CYCLES, 16, stable cycles needed to accept an input change (used only with GPIO_DEBOUNCE_EN); debounce counter width is clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- req_i  input  1  bus request
- we_i  input  1  write enable, qualified by req_i
- addr_i  input  32  byte address; addr_i[4:0] decoded
- data_i  input  32  write data
- data_o  output  32  read data, valid while ack_o=1
- ack_o  output  1  bus acknowledge
- gpio_i  input  NUM_PINS  pad inputs, asynchronous
- gpio_o  output  NUM_PINS  pad output values
- gpio_oe  output  NUM_PINS  pad output enables, 1 = drive
- irq_o  output  1  level interrupt to the interrupt controller

Behaviour:
Reset and timing base
- rst is asynchronous active-low and applies to all flops.
- Reset values: data_o=0, ack_o=0, gpio_o=0, gpio_oe=0 (all pins inputs), irq_o=0, all registers 0, synchroniser and edge-history flops 0.

Register map (addr_i[4:0])
- 0x00 DIR: RW. 1 = output.
- 0x04 DATA: RW. Drives gpio_o; legacy offset.
- 0x08 IN: RO. Synchronised pin levels; writes are ignored.
- 0x0C IE: RW. Per-pin interrupt enable.
- 0x10 EDGE: RW. 1 = rising edge, 0 = falling edge.
- 0x14 PEND: RW1C. Pending flags.
- Any other offset reads 0; writes to it are ignored.

Bus handshake
- A write takes effect on the clk edge where req_i=1 and we_i=1.
- ack_o is registered: it is 1 in the cycle after any req_i=1 cycle and 0 otherwise, so back-to-back requests give back-to-back acks.
- data_o is registered with ack_o and holds the selected register value sampled at the request edge. Otherwise data_o is 0.
- A read is one cycle latency.
- A read of the register being written in that same cycle returns the old value.

Input path and interrupts
- gpio_i passes through SYNC_STAGES flops to give sync_in; IN = sync_in.
- Input change latency is SYNC_STAGES cycles to IN.
- prev_in holds sync_in delayed by 1 cycle.
- An event occurs on pin n when (EDGE[n] & sync_in[n] & ~prev_in[n]) | (~EDGE[n] & ~sync_in[n] & prev_in[n]).
- Edges are detected regardless of IE or DIR, so output pins loop back through the pad.
- PEND[n] is set in the cycle after the event.
- When a PEND write of 1 and a new event on the same pin occur in the same cycle, the set wins.
- Writing 0 to a PEND bit has no effect.
- irq_o is registered: irq_o = |(PEND & IE).
- Clearing IE masks irq_o without clearing PEND.
- Changing EDGE never creates an event by itself; detection always uses prev_in.

Outputs
- gpio_o = DATA[NUM_PINS-1:0] and gpio_oe = DIR[NUM_PINS-1:0], both direct from the registers.
- Both update the cycle after the write.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: each pin has a counter after the synchroniser. A new level is accepted into sync_in/IN only after it stays stable for DEBOUNCE_CYCLES consecutive cycles; any bounce reloads the counter. Latency becomes SYNC_STAGES+DEBOUNCE_CYCLES cycles. Counters reset to 0.
- Undefined: no counters; behaviour is exactly as specified above.

Test Plan:
1. Reset: hold rst=0 mid-operation with DIR=0xFF and DATA=0xA5, then release -> gpio_oe=0x00, gpio_o=0x00, irq_o=0, and all register reads return 0.
2. Write DIR=0xFF, then DATA=0x3C at 0x04 -> gpio_oe=0xFF and gpio_o=0x3C the next cycle; read 0x04 -> ack_o one cycle after req_i, data_o=0x0000003C.
3. Set gpio_i=0x81 -> read IN=0x81 no earlier than 2 cycles later; a write to 0x08 is ignored; reads of 0x1C and of bits 31:8 return 0.
4. EDGE=0x01, IE=0x01, then pulse gpio_i[0] 0->1 -> PEND=0x01 and irq_o=1. A falling edge on pin 1 with EDGE[1]=0 and IE[1]=0 -> PEND=0x03 with irq_o still driven only by pin 0.
5. Write PEND=0x01 in the same cycle as a new rising event on pin 0 -> PEND[0] stays 1. Writing PEND=0x01 with no event -> PEND[0]=0 and irq_o=0 the following cycle.
6. With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, glitch gpio_i[2] high for 5 cycles -> IN[2] stays 0 and no PEND. Hold it high for 20 cycles -> IN[2]=1 at cycle SYNC_STAGES+16.
